// File: rtl/opr_shift_reg_if.sv
// opr_shift_reg_if: load/shift controls and digit/status outputs of the operand shift register
interface opr_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
);
    localparam int RW = $clog2(WIDTH / STEP + 1);
    logic             load_i;
    logic             shift_i;
    logic [WIDTH-1:0] din_i;
    logic [STEP-1:0]  dout_o;
    logic             dout_valid_o;
    logic [RW-1:0]    remaining_o;
    logic             done_o;
    logic             rest_zero_o;
    logic             overrun_o;
    modport slave (
        input  load_i, shift_i, din_i,
        output dout_o, dout_valid_o, remaining_o, done_o, rest_zero_o, overrun_o
    );
    modport master (
        output load_i, shift_i, din_i,
        input  dout_o, dout_valid_o, remaining_o, done_o, rest_zero_o, overrun_o
    );
endinterface

// File: rtl/opr_shift_reg.sv
// opr_shift_reg: multiplier operand shift register, emits STEP-bit digits LSB first
module opr_shift_reg #(
    parameter int WIDTH  = 8,
    parameter int STEP   = 1,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    opr_shift_reg_if.slave     bus
);
    localparam int DIGITS = WIDTH / STEP;
    localparam int RW     = $clog2(DIGITS + 1);

    if (WIDTH < 2 || (STEP != 1 && STEP != 2) || (WIDTH % STEP) != 0) begin : g_bad_param
        $error("opr_shift_reg: illegal WIDTH=%0d / STEP=%0d", WIDTH, STEP);
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [STEP-1:0]  dout_q, dout_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             fill;

    assign fill = (SIGNED != 0) ? reg_q[WIDTH-1] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // load beats shift; a shift outside ACTIVE only raises the sticky overrun
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        if (bus.load_i) begin
            reg_d   = bus.din_i;
            rem_d   = RW'(DIGITS);
            state_d = ACTIVE;
            ovr_d   = 1'b0;
        end else if (bus.shift_i) begin
            if (state_q == ACTIVE) begin
                dout_d  = reg_q[STEP-1:0];
                valid_d = 1'b1;
                reg_d   = {{STEP{fill}}, reg_q[WIDTH-1:STEP]};
                rem_d   = rem_q - RW'(1);
                state_d = (rem_q == RW'(1)) ? DONE : ACTIVE;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign bus.dout_o       = dout_q;
    assign bus.dout_valid_o = valid_q;
    assign bus.remaining_o  = rem_q;
    assign bus.done_o       = (state_q == DONE);
    assign bus.rest_zero_o  = (reg_q == {WIDTH{fill}});
    assign bus.overrun_o    = ovr_q;
endmodule

// File: tb/tb_opr_shift_reg.sv
// tb_opr_shift_reg: directed checks of radix-2, radix-4 and signed operand shifting
module tb_opr_shift_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    opr_shift_reg_if #(.WIDTH(8), .STEP(1)) b1 ();
    opr_shift_reg_if #(.WIDTH(8), .STEP(2)) b2 ();
    opr_shift_reg_if #(.WIDTH(8), .STEP(1)) b3 ();

    opr_shift_reg #(.WIDTH(8), .STEP(1), .SIGNED(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    opr_shift_reg #(.WIDTH(8), .STEP(2), .SIGNED(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    opr_shift_reg #(.WIDTH(8), .STEP(1), .SIGNED(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] op;
        logic [1:0] dig [4];
        rst_n = 1'b1;
        {b1.load_i, b1.shift_i, b1.din_i} = '0;
        {b2.load_i, b2.shift_i, b2.din_i} = '0;
        {b3.load_i, b3.shift_i, b3.din_i} = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_remaining", 32'(b1.remaining_o), 0);
        chk("rst_dout", 32'(b1.dout_o), 0);
        chk("rst_done", 32'(b1.done_o), 0);
        chk("rst_rest_zero", 32'(b1.rest_zero_o), 1);
        chk("rst_overrun", 32'(b1.overrun_o), 0);
        chk("rst_valid", 32'(b1.dout_valid_o), 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        // radix-2 drain of 0xB5
        op = 8'hB5;
        b1.load_i = 1'b1; b1.din_i = op;
        tick();
        b1.load_i = 1'b0;
        chk("t1_load_rem", 32'(b1.remaining_o), 8);
        chk("t1_load_valid", 32'(b1.dout_valid_o), 0);
        chk("t1_load_done", 32'(b1.done_o), 0);
        b1.shift_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t1_dout%0d", i), 32'(b1.dout_o), 32'(op[i]));
            chk($sformatf("t1_valid%0d", i), 32'(b1.dout_valid_o), 1);
            chk($sformatf("t1_rem%0d", i), 32'(b1.remaining_o), 32'(7 - i));
            chk($sformatf("t1_done%0d", i), 32'(b1.done_o), (i == 7) ? 1 : 0);
            chk($sformatf("t1_rz%0d", i), 32'(b1.rest_zero_o), ((op >> (i + 1)) == 0) ? 1 : 0);
        end
        // ninth shift lands in DONE
        tick();
        b1.shift_i = 1'b0;
        chk("t5_dout_hold", 32'(b1.dout_o), 1);
        chk("t5_valid", 32'(b1.dout_valid_o), 0);
        chk("t5_overrun", 32'(b1.overrun_o), 1);
        chk("t5_rem", 32'(b1.remaining_o), 0);
        tick();
        chk("t5_overrun_sticky", 32'(b1.overrun_o), 1);
        chk("t5_valid_idle", 32'(b1.dout_valid_o), 0);
        // load clears overrun; four shifts leave 0x0F, then load+shift together
        b1.load_i = 1'b1; b1.din_i = 8'hF0;
        tick();
        b1.load_i = 1'b0;
        chk("t5_load_clears_ovr", 32'(b1.overrun_o), 0);
        b1.shift_i = 1'b1;
        repeat (4) tick();
        chk("t4_pre_reg", 32'(dut1.reg_q), 32'h0F);
        chk("t4_pre_rem", 32'(b1.remaining_o), 4);
        b1.load_i = 1'b1; b1.din_i = 8'h3C;
        tick();
        b1.load_i = 1'b0; b1.shift_i = 1'b0;
        chk("t4_reg", 32'(dut1.reg_q), 32'h3C);
        chk("t4_rem", 32'(b1.remaining_o), 8);
        chk("t4_valid", 32'(b1.dout_valid_o), 0);
        chk("t4_overrun", 32'(b1.overrun_o), 0);
        chk("t4_dout_hold", 32'(b1.dout_o), 0);
        // radix-4 drain of 0xB5
        dig = '{2'b01, 2'b01, 2'b11, 2'b10};
        b2.load_i = 1'b1; b2.din_i = 8'hB5;
        tick();
        b2.load_i = 1'b0;
        chk("t2_load_rem", 32'(b2.remaining_o), 4);
        b2.shift_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_dout%0d", i), 32'(b2.dout_o), 32'(dig[i]));
            chk($sformatf("t2_rem%0d", i), 32'(b2.remaining_o), 32'(3 - i));
            chk($sformatf("t2_done%0d", i), 32'(b2.done_o), (i == 3) ? 1 : 0);
            chk($sformatf("t2_rz%0d", i), 32'(b2.rest_zero_o), (i == 3) ? 1 : 0);
        end
        b2.shift_i = 1'b0;
        // signed fill from 0x80
        b3.load_i = 1'b1; b3.din_i = 8'h80;
        tick();
        b3.load_i = 1'b0;
        b3.shift_i = 1'b1;
        tick();
        chk("t3_reg1", 32'(dut3.reg_q), 32'hC0);
        chk("t3_dout1", 32'(b3.dout_o), 0);
        chk("t3_rz1", 32'(b3.rest_zero_o), 0);
        repeat (6) tick();
        chk("t3_reg7", 32'(dut3.reg_q), 32'hFF);
        chk("t3_rz7", 32'(b3.rest_zero_o), 1);
        chk("t3_rem7", 32'(b3.remaining_o), 1);
        tick();
        b3.shift_i = 1'b0;
        chk("t3_dout8", 32'(b3.dout_o), 1);
        chk("t3_done8", 32'(b3.done_o), 1);
        // async reset after three shifts of 0x3C
        b1.shift_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_dout%0d", i), 32'(b1.dout_o), (i == 2) ? 1 : 0);
        end
        b1.shift_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rem", 32'(b1.remaining_o), 0);
        chk("t6_rst_dout", 32'(b1.dout_o), 0);
        chk("t6_rst_valid", 32'(b1.dout_valid_o), 0);
        chk("t6_rst_rz", 32'(b1.rest_zero_o), 1);
        chk("t6_rst_done", 32'(b1.done_o), 0);
        chk("t6_rst_ovr", 32'(b1.overrun_o), 0);
        #1 rst_n = 1'b1;
        b1.shift_i = 1'b1;
        tick();
        b1.shift_i = 1'b0;
        chk("t6_idle_ovr", 32'(b1.overrun_o), 1);
        chk("t6_idle_valid", 32'(b1.dout_valid_o), 0);
        chk("t6_idle_rem", 32'(b1.remaining_o), 0);
        chk("t6_idle_done", 32'(b1.done_o), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
